regfile_2r1w: RTL and testbench



---
 rtl/regfile_pkg.sv | 11 +
 rtl/dff_en.sv | 25 ++
 rtl/regfile_2r1w.sv | 84 ++++++++
 tb/tb_regfile_2r1w.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults for the register file and the datapath that instantiates it.
// The parameter defaults of regfile_2r1w come from here.
package regfile_pkg;

    localparam int WIDTH_DEF    = 32;
    localparam int ADDR_DEF     = 5;
    localparam bit ZERO_REG_DEF = 1'b1;
    localparam bit BYPASS_DEF   = 1'b1;
    localparam bit RD_REG_DEF   = 1'b0;

endpackage

// File: rtl/dff_en.sv
// Enabled register with asynchronous active-low reset to zero and a synchronous clear.
// The clear takes priority over the enable.
module dff_en #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/regfile_2r1w.sv
// Two-read, one-write register file with optional hardwired zero entry,
// write-to-read bypass and optional registered read ports.
module regfile_2r1w
    import regfile_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int ADDR     = ADDR_DEF,
    parameter bit ZERO_REG = ZERO_REG_DEF,
    parameter bit BYPASS   = BYPASS_DEF,
    parameter bit RD_REG   = RD_REG_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wen,
    input  logic [ADDR-1:0]  waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             ren,
    input  logic [ADDR-1:0]  raddr1,
    input  logic [ADDR-1:0]  raddr2,
    output logic [WIDTH-1:0] rdata1,
    output logic [WIDTH-1:0] rdata2
);

    localparam int DEPTH = 2 ** ADDR;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rv1;
    logic [WIDTH-1:0] rv2;
    logic             wr_live;

    // A write only becomes visible when it will actually commit: not under clear or reset.
    assign wr_live = wen && !clr && rst_n;

    // NOTE: the array is built from resettable flops because reset must clear every entry at once;
    // a RAM macro cannot do that, so no memory inference is expected here.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        if (ZERO_REG && i == 0) begin : g_zero
            assign mem[i] = '0;
        end else begin : g_reg
            dff_en #(.WIDTH(WIDTH)) u_entry (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (clr),
                .en    (wen && (waddr == ADDR'(i))),
                .d     (wdata),
                .q     (mem[i])
            );
        end
    end

    assign rv1 = (ZERO_REG && raddr1 == '0)               ? '0    :
                 (BYPASS && wr_live && waddr == raddr1)   ? wdata :
                                                            mem[raddr1];
    assign rv2 = (ZERO_REG && raddr2 == '0)               ? '0    :
                 (BYPASS && wr_live && waddr == raddr2)   ? wdata :
                                                            mem[raddr2];

    if (RD_REG) begin : g_rd_reg
        dff_en #(.WIDTH(WIDTH)) u_rd1 (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr),
            .en    (ren),
            .d     (rv1),
            .q     (rdata1)
        );
        dff_en #(.WIDTH(WIDTH)) u_rd2 (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr),
            .en    (ren),
            .d     (rv2),
            .q     (rdata2)
        );
    end else begin : g_rd_comb
        // ren has no meaning for combinational reads.
        logic unused_ren;
        assign unused_ren = ren;
        assign rdata1     = rv1;
        assign rdata2     = rv2;
    end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench for regfile_2r1w: four configurations share one stimulus stream;
// expected values are queued by the stimulus and compared by a separate monitor.
module tb_regfile_2r1w;

    localparam int W = 32;
    localparam int A = 5;

    typedef enum int {
        S_D0_R1, S_D0_R2,   // ZERO_REG=1 BYPASS=1 RD_REG=0
        S_NB_R1, S_NB_R2,   // ZERO_REG=1 BYPASS=0 RD_REG=0
        S_RR_R1, S_RR_R2,   // ZERO_REG=1 BYPASS=1 RD_REG=1
        S_RN_R1             // ZERO_REG=1 BYPASS=0 RD_REG=1
    } src_e;

    typedef struct {
        string          name;
        src_e           src;
        logic [W-1:0]   exp;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         clr;
    logic         wen;
    logic [A-1:0] waddr;
    logic [W-1:0] wdata;
    logic         ren;
    logic [A-1:0] raddr1;
    logic [A-1:0] raddr2;

    logic [W-1:0] d0_r1, d0_r2, nb_r1, nb_r2, rr_r1, rr_r2, rn_r1, rn_r2;

    exp_t sb[$];
    event sample_ev;
    int   errors = 0;
    int   checks = 0;

    regfile_2r1w #(.WIDTH(W), .ADDR(A), .ZERO_REG(1'b1), .BYPASS(1'b1), .RD_REG(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wen(wen), .waddr(waddr), .wdata(wdata),
        .ren(ren), .raddr1(raddr1), .raddr2(raddr2), .rdata1(d0_r1), .rdata2(d0_r2)
    );
    regfile_2r1w #(.WIDTH(W), .ADDR(A), .ZERO_REG(1'b1), .BYPASS(1'b0), .RD_REG(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wen(wen), .waddr(waddr), .wdata(wdata),
        .ren(ren), .raddr1(raddr1), .raddr2(raddr2), .rdata1(nb_r1), .rdata2(nb_r2)
    );
    regfile_2r1w #(.WIDTH(W), .ADDR(A), .ZERO_REG(1'b1), .BYPASS(1'b1), .RD_REG(1'b1)) dut_rr (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wen(wen), .waddr(waddr), .wdata(wdata),
        .ren(ren), .raddr1(raddr1), .raddr2(raddr2), .rdata1(rr_r1), .rdata2(rr_r2)
    );
    regfile_2r1w #(.WIDTH(W), .ADDR(A), .ZERO_REG(1'b1), .BYPASS(1'b0), .RD_REG(1'b1)) dut_rn (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wen(wen), .waddr(waddr), .wdata(wdata),
        .ren(ren), .raddr1(raddr1), .raddr2(raddr2), .rdata1(rn_r1), .rdata2(rn_r2)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic logic [W-1:0] pick(input src_e s);
        case (s)
            S_D0_R1: return d0_r1;
            S_D0_R2: return d0_r2;
            S_NB_R1: return nb_r1;
            S_NB_R2: return nb_r2;
            S_RR_R1: return rr_r1;
            S_RR_R2: return rr_r2;
            S_RN_R1: return rn_r1;
            default: return 'x;
        endcase
    endfunction

    // Monitor: drains the scoreboard each time the stimulus presents a settled sample point.
    initial begin
        forever begin
            @(sample_ev);
            while (sb.size() > 0) begin
                exp_t         e;
                logic [W-1:0] act;
                e   = sb.pop_front();
                act = pick(e.src);
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %h, expected %h (t=%0t)", e.name, act, e.exp, $time);
                end
            end
        end
    end

    task automatic expect_val(input string name, input src_e src, input logic [W-1:0] v);
        exp_t e;
        e.name = name;
        e.src  = src;
        e.exp  = v;
        sb.push_back(e);
    endtask

    // Settle combinational paths, hand the queued expectations to the monitor, step past it.
    task automatic check();
        #1;
        ->sample_ev;
        #1;
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; wen = 1'b0; waddr = '0; wdata = '0;
        ren = 1'b0; raddr1 = '0; raddr2 = '0;

        expect_val("reset_d0_r1", S_D0_R1, 32'h0);
        expect_val("reset_rr_r1", S_RR_R1, 32'h0);
        expect_val("reset_rr_r2", S_RR_R2, 32'h0);
        check();

        // Write entry 5; bypass shows it before the edge, no-bypass does not.
        rst_n = 1'b1;
        wen = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; raddr1 = 5'd5; ren = 1'b1;
        expect_val("bypass_pre_edge", S_D0_R1, 32'hDEADBEEF);
        expect_val("nobypass_pre_edge", S_NB_R1, 32'h0);
        check();
        cyc();
        wen = 1'b0; ren = 1'b0;
        expect_val("write5_d0", S_D0_R1, 32'hDEADBEEF);
        expect_val("write5_nb", S_NB_R1, 32'hDEADBEEF);
        expect_val("rdreg_bypass_same_edge", S_RR_R1, 32'hDEADBEEF);
        expect_val("rdreg_nobypass_same_edge", S_RN_R1, 32'h0);
        check();

        // Asynchronous reset between edges clears array and read registers.
        rst_n = 1'b0;
        expect_val("async_reset_d0", S_D0_R1, 32'h0);
        expect_val("async_reset_nb", S_NB_R1, 32'h0);
        expect_val("async_reset_rr", S_RR_R1, 32'h0);
        check();

        // Write attempted while in reset must not land or forward.
        wen = 1'b1; waddr = 5'd6; wdata = 32'h66; raddr2 = 5'd6;
        expect_val("reset_no_forward", S_D0_R2, 32'h0);
        check();
        cyc();
        rst_n = 1'b1;
        expect_val("reset_write_dropped", S_NB_R2, 32'h0);
        expect_val("forward_after_release", S_D0_R2, 32'h66);
        check();
        cyc();
        wen = 1'b0;
        expect_val("first_write_after_reset_nb", S_NB_R2, 32'h66);
        expect_val("first_write_after_reset_d0", S_D0_R2, 32'h66);
        check();

        // Basic write/read on both ports, then a disabled write.
        wen = 1'b1; waddr = 5'd7; wdata = 32'd15; raddr1 = 5'd7; raddr2 = 5'd7;
        cyc();
        wen = 1'b0; wdata = 32'd20;
        expect_val("basic_r1", S_D0_R1, 32'd15);
        expect_val("basic_r2", S_D0_R2, 32'd15);
        expect_val("basic_nb_r1", S_NB_R1, 32'd15);
        check();
        cyc();
        expect_val("wen0_hold_r1", S_NB_R1, 32'd15);
        expect_val("wen0_hold_r2", S_NB_R2, 32'd15);
        check();

        // Entry 0 is hardwired zero, including through bypass.
        wen = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr1 = 5'd0;
        expect_val("zero_bypass", S_D0_R1, 32'h0);
        check();
        cyc();
        wen = 1'b0;
        expect_val("zero_after_write_d0", S_D0_R1, 32'h0);
        expect_val("zero_after_write_nb", S_NB_R1, 32'h0);
        check();

        // Overwrite entry 3: bypass sees new data before the edge, no-bypass sees old.
        wen = 1'b1; waddr = 5'd3; wdata = 32'd11;
        cyc();
        wdata = 32'd25; raddr2 = 5'd3;
        expect_val("bypass_new_r2", S_D0_R2, 32'd25);
        expect_val("nobypass_old_r2", S_NB_R2, 32'd11);
        check();
        cyc();
        wen = 1'b0;
        expect_val("nobypass_after_edge", S_NB_R2, 32'd25);
        expect_val("bypass_after_edge", S_D0_R2, 32'd25);
        check();

        for (int i = 1; i <= 4; i++) begin
            wen = 1'b1; waddr = A'(i); wdata = 32'd30;
            cyc();
        end
        wen = 1'b0;

        // Registered read: load with ren=1, then hold with ren=0 while the address moves.
        raddr1 = 5'd4; ren = 1'b1;
        expect_val("entry4_comb", S_D0_R1, 32'd30);
        check();
        cyc();
        ren = 1'b0; raddr1 = 5'd7;
        expect_val("rdreg_load", S_RR_R1, 32'd30);
        expect_val("comb_follows_addr", S_D0_R1, 32'd15);
        check();
        cyc();
        expect_val("rdreg_hold", S_RR_R1, 32'd30);
        check();

        // Clear wins over a simultaneous write and also zeroes the read registers.
        raddr1 = 5'd2; raddr2 = 5'd4; clr = 1'b1; wen = 1'b1; waddr = 5'd2; wdata = 32'd99;
        expect_val("clr_blocks_bypass", S_D0_R1, 32'd30);
        check();
        cyc();
        clr = 1'b0; wen = 1'b0;
        expect_val("clr_entry2", S_D0_R1, 32'h0);
        expect_val("clr_entry4", S_D0_R2, 32'h0);
        expect_val("clr_entry2_nb", S_NB_R1, 32'h0);
        expect_val("clr_rdreg", S_RR_R1, 32'h0);
        check();
        raddr1 = 5'd7;
        expect_val("clr_entry7", S_D0_R1, 32'h0);
        check();

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
